lol_word_detector: RTL
======================

Name: lol_word_detector

Overview:
Sits directly downstream of lol_reader and consumes its L, O and Y letter-recognition outputs. Turns those levels into single letter events and tracks the letter stream with a small FSM. Emits a one-cycle pulse each time the word "LOL" completes, with overlap allowed, and keeps a saturating count of detected words. Flags illegal multi-letter events with a sticky error bit.

Parameters:
COUNT_W, 4, width of the saturating word counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
L  input  1  letter-L recognized level from lol_reader
O  input  1  letter-O recognized level from lol_reader
Y  input  1  letter-Y recognized level from lol_reader
clear  input  1  synchronous clear of FSM, counter and error flag
lol  output  1  one-cycle pulse when "LOL" completes
word_count  output  COUNT_W  number of "LOL" detections, saturating
err  output  1  sticky; set when two or more letters rise on the same edge
state  output  2  current FSM state, for debug: 0 IDLE, 1 GOT_L, 2 GOT_LO

Behaviour:
- Reset (async, active-high): state=IDLE, lol=0, word_count=0, err=0, prev_L/O/Y=0. All outputs are registered.
- Edge detect: prev_X <= X every clock. riseX = X & ~prev_X. A letter held high for many cycles counts once. A letter already high when reset releases counts as a rise on the first edge.
- Event classification:
  - Exactly one rise = letter event.
  - Zero rises = no event. State holds and lol=0.
  - Two or more rises = illegal. err<=1, state<=IDLE, lol=0, count unchanged.
- FSM transitions on a letter event:
  - IDLE: L->GOT_L. O or Y->IDLE.
  - GOT_L: L->GOT_L. O->GOT_LO. Y->IDLE.
  - GOT_LO: L->GOT_L, with detection. O or Y->IDLE.
- Detection: lol=1 for exactly the one cycle following the edge that sampled the completing L rise. Latency is 1 clock from that edge. lol=0 in every other cycle.
- Overlap: the final L of a word is the first L of the next word. "LOLOL" gives 2 pulses.
- word_count increments by 1 on each detection. At all-ones (15 at default) it holds; a detection at saturation still pulses lol.
- err: once set, stays set until reset or clear. It does not block later detection.
- clear (sync, while reset=0): next edge gives state=IDLE, lol=0, word_count=0, err=0.
  - prev_L/O/Y still update, so a level held across clear does not re-trigger.
  - clear overrides any same-edge event, including a completing L: no pulse, no increment.
- Reset mid-word (e.g., in GOT_LO) returns to IDLE immediately. A following "L" alone does not detect.
- Inputs are synchronous to clk. No synchronizers.

Test Plan:
- Reset release, then L, O, L rises separated by low cycles, each held 2 cycles -> state goes 1, 2, 1. lol=1 for exactly one cycle after the edge sampling the second L rise. word_count=1. err=0.
- Stream L,O,L,O,L -> 2 lol pulses, word_count=2. Stream L,O,Y,L -> no pulse, state=1 at end.
- L and O rise on the same edge while in GOT_L -> err=1, state=0, word_count unchanged. A following L,O,L still pulses lol and word_count increments.
- 16 back-to-back LOL words with COUNT_W=4 -> word_count reaches 15 and holds. lol still pulses on the 16th word.
- Assert clear on the same edge as a completing L (state=2, word_count=3, err=1) -> next cycle lol=0, word_count=0, err=0, state=0. The held L does not re-trigger on later edges.
- Assert reset asynchronously mid-cycle while in GOT_LO -> outputs zero before the next edge. After release, a single L gives state=1 and no pulse.

Source files
------------

// File: rtl/lol_word_detector.sv
// Word detector for the L/O/Y letter stream from lol_reader: pulses lol on each
// "LOL" (overlapping), keeps a saturating word count and a sticky illegal-event flag.
//
// state  | meaning
// -------+-------------------------------------------
// IDLE   | no partial word in progress
// GOT_L  | last letter event was an L
// GOT_LO | last two letter events were L then O
module lol_word_detector #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               O,
    input  logic               Y,
    input  logic               clear,
    output logic               lol,
    output logic [COUNT_W-1:0] word_count,
    output logic               err,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_L  = 2'd1,
        GOT_LO = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t             cur_state;
    state_t             nxt_state;
    logic               prev_l;
    logic               prev_o;
    logic               prev_y;
    logic               rise_l;
    logic               rise_o;
    logic               rise_y;
    logic               one_rise;
    logic               multi_rise;
    logic               lol_nxt;
    logic               err_nxt;
    logic [COUNT_W-1:0] count_nxt;

    assign rise_l = L & ~prev_l;
    assign rise_o = O & ~prev_o;
    assign rise_y = Y & ~prev_y;

    assign multi_rise = (rise_l & rise_o) | (rise_l & rise_y) | (rise_o & rise_y);
    assign one_rise   = (rise_l | rise_o | rise_y) & ~multi_rise;

    // Letter history keeps updating through clear so a held level never re-fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_l     <= 1'b0;
            prev_o     <= 1'b0;
            prev_y     <= 1'b0;
            cur_state  <= IDLE;
            lol        <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            prev_l     <= L;
            prev_o     <= O;
            prev_y     <= Y;
            cur_state  <= nxt_state;
            lol        <= lol_nxt;
            word_count <= count_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        lol_nxt   = 1'b0;
        count_nxt = word_count;
        err_nxt   = err;
        if (clear) begin
            nxt_state = IDLE;
            count_nxt = '0;
            err_nxt   = 1'b0;
        end else if (multi_rise) begin
            nxt_state = IDLE;
            err_nxt   = 1'b1;
        end else if (one_rise) begin
            case (cur_state)
                IDLE: begin
                    nxt_state = rise_l ? GOT_L : IDLE;
                end
                GOT_L: begin
                    if (rise_l)
                        nxt_state = GOT_L;
                    else if (rise_o)
                        nxt_state = GOT_LO;
                    else
                        nxt_state = IDLE;
                end
                GOT_LO: begin
                    if (rise_l) begin
                        // Completing L doubles as the first L of the next word.
                        nxt_state = GOT_L;
                        lol_nxt   = 1'b1;
                        if (word_count != COUNT_MAX)
                            count_nxt = word_count + 1'b1;
                    end else begin
                        nxt_state = IDLE;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule
